// File: rtl/coin_turn_ctrl.sv
// Turn scheduler and drop sequencer for the two-player coin game.
// Optional idle-timeout turn pass is built only when COIN_TURN_TIMEOUT_EN is defined.
module coin_turn_ctrl #(
   parameter int NUM_COLS       = 10,
   parameter int NUM_ROWS       = 6,
   parameter int COL_WIDTH      = 64,
`ifdef COIN_TURN_TIMEOUT_EN
   parameter int DROP_TICKS     = 4,
   parameter int TIMEOUT_CYCLES = 1000
`else
   parameter int DROP_TICKS     = 4
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] player_left,
   input  logic [9:0] player_right,
   input  logic       drop_left,
   input  logic       drop_right,
   input  logic       clear,
   output logic [3:0] coin_col,
   output logic [3:0] coin_row,
   output logic       coin_active,
   output logic       coin_owner,
   output logic       turn,
   output logic       landed,
   output logic       reject,
   output logic       board_full
);

   localparam int TICK_W = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DROP = 2'd1,
      ST_LAND = 2'd2
   } state_t;

   state_t              r_state;
   logic [TICK_W-1:0]   r_tick;
   logic [3:0]          r_height [NUM_COLS];
   logic [3:0]          r_coin_col;
   logic [3:0]          r_coin_row;
   logic                r_coin_active;
   logic                r_coin_owner;
   logic                r_turn;
   logic                r_landed;
   logic                r_reject;
   logic                r_board_full;

`ifdef COIN_TURN_TIMEOUT_EN
   localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [IDLE_W-1:0]   r_idle_cnt;
`endif

   logic                w_req;
   logic [9:0]          w_pos;
   logic [31:0]         w_quot;
   logic                w_col_ok;
   logic [3:0]          w_col;
   logic [3:0]          w_req_height;
   logic [3:0]          w_cur_height;
   logic                w_all_full;
   logic                w_refuse;

   // Only the turn player's request and position are looked at.
   assign w_req    = r_turn ? drop_right : drop_left;
   assign w_pos    = r_turn ? player_right : player_left;
   assign w_quot   = {22'd0, w_pos} / 32'(COL_WIDTH);
   assign w_col_ok = (w_quot < 32'(NUM_COLS));
   assign w_col    = w_quot[3:0];

   // Height lookups for the requested column and the falling coin's column.
   always_comb begin
      w_req_height = 4'd0;
      w_cur_height = 4'd0;
      w_all_full   = 1'b1;
      for (int c = 0; c < NUM_COLS; c++) begin
         w_req_height = (w_col == 4'(c))      ? r_height[c] : w_req_height;
         w_cur_height = (r_coin_col == 4'(c)) ? r_height[c] : w_cur_height;
         w_all_full   = w_all_full & (r_height[c] == 4'(NUM_ROWS));
      end
   end

   assign w_refuse = !w_col_ok || (w_req_height == 4'(NUM_ROWS)) || r_board_full;

   // Turn / drop / land sequencer with board bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_tick        <= '0;
         r_coin_col    <= 4'd0;
         r_coin_row    <= 4'd0;
         r_coin_active <= 1'b0;
         r_coin_owner  <= 1'b0;
         r_turn        <= 1'b0;
         r_landed      <= 1'b0;
         r_reject      <= 1'b0;
         r_board_full  <= 1'b0;
         for (int c = 0; c < NUM_COLS; c++) begin
            r_height[c] <= 4'd0;
         end
`ifdef COIN_TURN_TIMEOUT_EN
         r_idle_cnt    <= '0;
`endif
      end else if (clear) begin
         // Clear wins over everything, including a same-cycle request.
         r_state       <= ST_IDLE;
         r_tick        <= '0;
         r_coin_active <= 1'b0;
         r_turn        <= 1'b0;
         r_landed      <= 1'b0;
         r_reject      <= 1'b0;
         r_board_full  <= 1'b0;
         for (int c = 0; c < NUM_COLS; c++) begin
            r_height[c] <= 4'd0;
         end
`ifdef COIN_TURN_TIMEOUT_EN
         r_idle_cnt    <= '0;
`endif
      end else begin
         r_landed     <= 1'b0;
         r_reject     <= 1'b0;
         r_board_full <= w_all_full;
`ifdef COIN_TURN_TIMEOUT_EN
         r_idle_cnt   <= '0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  if (w_refuse) begin
                     r_reject <= 1'b1;
                  end else begin
                     r_coin_col    <= w_col;
                     r_coin_owner  <= r_turn;
                     r_coin_row    <= 4'(NUM_ROWS - 1);
                     r_coin_active <= 1'b1;
                     r_tick        <= '0;
                     r_state       <= ST_DROP;
                  end
               end else begin
`ifdef COIN_TURN_TIMEOUT_EN
                  if (!r_board_full) begin
                     if (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        r_turn <= ~r_turn;
                     end else begin
                        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                     end
                  end else begin
                     r_idle_cnt <= '0;
                  end
`else
                  r_state <= ST_IDLE;
`endif
               end
            end
            ST_DROP: begin
               if (r_tick == TICK_W'(DROP_TICKS - 1)) begin
                  r_tick <= '0;
                  if (r_coin_row > w_cur_height) begin
                     r_coin_row <= r_coin_row - 4'd1;
                  end else begin
                     r_landed <= 1'b1;
                     r_state  <= ST_LAND;
                  end
               end else begin
                  r_tick <= r_tick + TICK_W'(1);
               end
            end
            ST_LAND: begin
               for (int c = 0; c < NUM_COLS; c++) begin
                  if (r_coin_col == 4'(c)) begin
                     r_height[c] <= r_height[c] + 4'd1;
                  end else begin
                     r_height[c] <= r_height[c];
                  end
               end
               r_turn        <= ~r_turn;
               r_coin_active <= 1'b0;
               r_state       <= ST_IDLE;
            end
            default: begin
               r_coin_active <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign coin_col    = r_coin_col;
   assign coin_row    = r_coin_row;
   assign coin_active = r_coin_active;
   assign coin_owner  = r_coin_owner;
   assign turn        = r_turn;
   assign landed      = r_landed;
   assign reject      = r_reject;
   assign board_full  = r_board_full;

endmodule

// File: tb/tb_coin_turn_ctrl.sv
// Directed self-checking bench for coin_turn_ctrl (default parameters).
// Honours COIN_TURN_TIMEOUT_EN for the idle-timeout expectation.
module tb_coin_turn_ctrl;

   logic       clk;
   logic       rst_n;
   logic [9:0] player_left;
   logic [9:0] player_right;
   logic       drop_left;
   logic       drop_right;
   logic       clear;
   logic [3:0] coin_col;
   logic [3:0] coin_row;
   logic       coin_active;
   logic       coin_owner;
   logic       turn;
   logic       landed;
   logic       reject;
   logic       board_full;

   int n_cmp = 0;
   int n_err = 0;

   coin_turn_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .player_left  (player_left),
      .player_right (player_right),
      .drop_left    (drop_left),
      .drop_right   (drop_right),
      .clear        (clear),
      .coin_col     (coin_col),
      .coin_row     (coin_row),
      .coin_active  (coin_active),
      .coin_owner   (coin_owner),
      .turn         (turn),
      .landed       (landed),
      .reject       (reject),
      .board_full   (board_full)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic side, input logic [9:0] pos);
      if (side) begin
         player_right = pos;
         drop_right   = 1'b1;
      end else begin
         player_left  = pos;
         drop_left    = 1'b1;
      end
      tick();
      drop_left  = 1'b0;
      drop_right = 1'b0;
   endtask

   // Counts edges after the accept until landed rises (bounded).
   task automatic land_wait(output int n);
      n = 0;
      while (landed !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      int  n;
      logic exp_turn;
      int  land_seen;

      rst_n        = 1'b0;
      player_left  = 10'd0;
      player_right = 10'd0;
      drop_left    = 1'b0;
      drop_right   = 1'b0;
      clear        = 1'b0;
      #12;
      check_eq("rst_turn",   turn,        1'b0);
      check_eq("rst_active", coin_active, 1'b0);
      check_eq("rst_col",    coin_col,    4'd0);
      check_eq("rst_row",    coin_row,    4'd0);
      check_eq("rst_owner",  coin_owner,  1'b0);
      check_eq("rst_landed", landed,      1'b0);
      check_eq("rst_reject", reject,      1'b0);
      check_eq("rst_full",   board_full,  1'b0);
      #10;
      rst_n = 1'b1;
      tick();

      // First drop: left at 130 -> column 2, rows 5..0 four cycles each.
      request(1'b0, 10'd130);
      check_eq("t1_active", coin_active, 1'b1);
      check_eq("t1_col",    coin_col,    4'd2);
      check_eq("t1_owner",  coin_owner,  1'b0);
      for (int r = 5; r >= 0; r--) begin
         for (int k = 0; k < 4; k++) begin
            check_eq("t1_row_hold", coin_row, 32'(r));
            check_eq("t1_no_land",  landed,   1'b0);
            tick();
         end
      end
      check_eq("t1_landed",      landed,      1'b1);
      check_eq("t1_land_active", coin_active, 1'b1);
      check_eq("t1_land_row",    coin_row,    4'd0);
      tick();
      check_eq("t1_landed_off", landed,      1'b0);
      check_eq("t1_active_off", coin_active, 1'b0);
      check_eq("t1_turn",       turn,        1'b1);
      check_eq("t1_col_hold",   coin_col,    4'd2);

      // Both requests together on right's turn: only right is taken.
      player_left  = 10'd130;
      player_right = 10'd600;
      drop_left    = 1'b1;
      drop_right   = 1'b1;
      tick();
      drop_left    = 1'b0;
      drop_right   = 1'b0;
      check_eq("t2_col",    coin_col,   4'd9);
      check_eq("t2_owner",  coin_owner, 1'b1);
      check_eq("t2_reject", reject,     1'b0);
      land_wait(n);
      check_eq("t2_cycles", n,        32'd24);
      check_eq("t2_row",    coin_row, 4'd0);
      tick();
      check_eq("t2_turn", turn, 1'b0);

      // Out-of-range position and off-turn request.
      request(1'b0, 10'd700);
      check_eq("t4_reject",  reject,      1'b1);
      check_eq("t4_active",  coin_active, 1'b0);
      check_eq("t4_turn",    turn,        1'b0);
      tick();
      check_eq("t4_reject_pulse", reject, 1'b0);
      request(1'b1, 10'd100);
      check_eq("t4_offturn_reject", reject,      1'b0);
      check_eq("t4_offturn_active", coin_active, 1'b0);

      // Clear mid-fall: column 2 has height 1, row 3 reached after 8 edges.
      request(1'b0, 10'd140);
      for (int k = 0; k < 8; k++) tick();
      check_eq("t5_row3", coin_row, 4'd3);
      do_clear();
      check_eq("t5_active", coin_active, 1'b0);
      check_eq("t5_landed", landed,      1'b0);
      check_eq("t5_turn",   turn,        1'b0);
      check_eq("t5_full",   board_full,  1'b0);
      land_seen = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (landed === 1'b1) land_seen++;
      end
      check_eq("t5_no_land", land_seen, 32'd0);

      // Six alternating drops into column 2 after clear: heights start at 0.
      exp_turn = 1'b0;
      for (int i = 0; i < 6; i++) begin
         request(exp_turn, 10'(128 + i * 10));
         check_eq("t3_col", coin_col, 4'd2);
         land_wait(n);
         check_eq("t3_cycles", n,        32'((6 - i) * 4));
         check_eq("t3_row",    coin_row, 32'(i));
         tick();
         exp_turn = ~exp_turn;
         check_eq("t3_turn", turn, exp_turn);
      end
      request(1'b0, 10'd150);
      check_eq("t3_full_reject", reject,      1'b1);
      check_eq("t3_full_active", coin_active, 1'b0);
      check_eq("t3_full_turn",   turn,        1'b0);

      // Fill all 60 slots.
      do_clear();
      exp_turn = 1'b0;
      for (int c = 0; c < 10; c++) begin
         for (int r = 0; r < 6; r++) begin
            request(exp_turn, 10'(c * 64 + 5 + r));
            land_wait(n);
            check_eq("t6_land", landed,   1'b1);
            check_eq("t6_row",  coin_row, 32'(r));
            tick();
            exp_turn = ~exp_turn;
         end
      end
      check_eq("t6_full_early", board_full, 1'b0);
      tick();
      check_eq("t6_full", board_full, 1'b1);
      request(1'b0, 10'd10);
      check_eq("t6_reject", reject,      1'b1);
      check_eq("t6_active", coin_active, 1'b0);

      // Idle timeout behaviour from a cleared board.
      do_clear();
`ifdef COIN_TURN_TIMEOUT_EN
      for (int k = 0; k < 999; k++) tick();
      check_eq("t7_turn_before", turn, 1'b0);
      tick();
      check_eq("t7_turn_after", turn, 1'b1);
`else
      for (int k = 0; k < 5000; k++) tick();
      check_eq("t7_turn_hold", turn, 1'b0);
`endif
      check_eq("t7_reject", reject, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/coin_turn_ctrl.md
Name: coin_turn_ctrl

Overview:
- Turn scheduler and drop sequencer for the two-player coin game.
- Arbitrates drop requests from the left and right players and maps the active player's 10-bit horizontal position to a board column.
- Tracks per-column fill height and steps a falling coin row by row to its landing slot.
- Outputs column, row, owner and active flag to the coin display driver; alternates turns after each landing.

Parameters:
- NUM_COLS, 10, board columns; must be ≤ 16.
- NUM_ROWS, 6, board rows; must be ≤ 15.
- COL_WIDTH, 64, pixels per column; column = position / COL_WIDTH.
- DROP_TICKS, 4, clock cycles each row is displayed during a fall; must be ≥ 1.
- TIMEOUT_CYCLES, 1000, idle cycles before a forced turn pass; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- player_left  in  10  left player horizontal position, 0..639.
- player_right  in  10  right player horizontal position, 0..639.
- drop_left  in  1  single-cycle drop request, left player.
- drop_right  in  1  single-cycle drop request, right player.
- clear  in  1  synchronous board clear.
- coin_col  out  4  column of the falling or just-landed coin.
- coin_row  out  4  current row of the falling coin; 0 = bottom.
- coin_active  out  1  high while a coin is falling or landing.
- coin_owner  out  1  owner of the moving coin; 0 = left, 1 = right.
- turn  out  1  player whose drop is accepted next; 0 = left.
- landed  out  1  one-cycle pulse when a coin settles.
- reject  out  1  one-cycle pulse when a turn-player request is refused.
- board_full  out  1  high when every column holds NUM_ROWS coins.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. turn, coin_col, coin_row, coin_active, coin_owner, landed, reject and board_full all 0. All height[c] = 0. Tick counter = 0.
- IDLE state:
  - Only the request of the turn player is examined. A request from the other player is ignored with no reject, including when both requests arrive in the same cycle.
  - col = pos / COL_WIDTH, computed combinationally.
  - The request is rejected (reject pulses the next cycle, state stays IDLE) if col ≥ NUM_COLS, height[col] == NUM_ROWS, or board_full.
  - Otherwise, on the accept edge: coin_col = col, coin_owner = turn, coin_row = NUM_ROWS-1, coin_active = 1, go to DROP.
- DROP state:
  - The tick counter counts 0..DROP_TICKS-1.
  - At terminal count: if coin_row > height[coin_col], decrement coin_row and reset the counter; otherwise go to LAND.
  - Each row is therefore held for exactly DROP_TICKS cycles. Time in DROP = (NUM_ROWS - height) × DROP_TICKS cycles.
- LAND state, exactly 1 cycle:
  - landed = 1, coin_active stays 1.
  - On exit: height[coin_col] += 1, turn toggles, coin_active = 0, return to IDLE. coin_col and coin_row hold their last values.
- board_full is registered and updates the cycle after the height increment.
- Requests arriving in DROP or LAND are ignored with no reject and no queuing.
- clear: highest priority in every state.
  - Aborts any fall; coin_active = 0, landed not pulsed.
  - All heights = 0, turn = 0, board_full = 0, state IDLE.
  - A drop request in the same cycle as clear is discarded.
- Width rules: heights are 4 bits. Position divide is integer truncation, which may be implemented as a shift when COL_WIDTH is a power of two.

Optional Feature:
- Macro: COIN_TURN_TIMEOUT_EN.
- Defined: an idle counter runs while in IDLE and not board_full. It resets on any accepted drop, reject or clear. When it reaches TIMEOUT_CYCLES-1, turn toggles and the counter restarts. No landed or reject pulse is produced.
- Undefined: no counter is built; turn changes only after LAND or clear.

Test Plan:
- Reset, then drop_left with player_left=130 → accepted; coin_col=2, coin_owner=0, coin_row steps 5,4,3,2,1,0, each held 4 cycles (24 cycles total). landed pulses 1 cycle, then turn=1 and coin_active=0.
- Same cycle drop_left=1 and drop_right=1 with turn=1, player_right=600 → only the right request is taken; coin_col=9, and the coin lands at row 0 after 24 cycles.
- Six alternating drops into column 2 (positions 128..191), then a seventh request → 6th coin lands at row 5 after 4 cycles in DROP; 7th pulses reject, turn unchanged, state IDLE.
- player_left=640..1023 on left's turn → reject pulses, no coin_active; a drop_right on left's turn → no reject, ignored.
- Assert clear mid-fall at coin_row=3 → next cycle coin_active=0, no landed pulse, turn=0, all heights=0. Then fill all 60 slots → board_full=1 one cycle after the final landing, and later requests pulse reject.
- With COIN_TURN_TIMEOUT_EN and TIMEOUT_CYCLES=1000: idle 1000 cycles on turn=0 → turn becomes 1. Without the macro, idle 5000 cycles → turn stays 0.
